// File: rtl/rbfu_writeback.sv
// RBFU write-back stage: aligns issue tokens with RBFU results after the
// opcode/radix-dependent latency, buffers result lanes in a FWFT FIFO and
// drives the coefficient-memory write port with a valid/ready handshake.
// Optional feature macro: RBFU_WB_RANGE_CHECK_EN (sticky err on lane data >= 3329).
module rbfu_writeback #(
    parameter int unsigned DW         = 12,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned LAT_R2     = 1,
    parameter int unsigned LAT_R4     = 2,
    parameter int unsigned LAT_PWM    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    output logic                iss_ready,
    input  logic [1:0]          iss_opcode,
    input  logic                iss_radix,
    input  logic [4*ADDR_W-1:0] iss_addr,
    input  logic [4*DW-1:0]     rbfu_dout,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [4*ADDR_W-1:0] wb_addr,
    output logic [4*DW-1:0]     wb_data,
    output logic [3:0]          wb_mask,
    output logic                busy,
    output logic                err
);

    localparam int unsigned MAX_LAT_A = (LAT_R2 > LAT_R4) ? LAT_R2 : LAT_R4;
    localparam int unsigned MAX_LAT   = (MAX_LAT_A > LAT_PWM) ? MAX_LAT_A : LAT_PWM;
    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W     = PTR_W + 1;

    // Delay line: slot k holds the token whose result appears in k cycles.
    logic [MAX_LAT:1]    slot_vld_q, slot_vld_d;
    logic [4*ADDR_W-1:0] slot_addr_q [1:MAX_LAT];
    logic [4*ADDR_W-1:0] slot_addr_d [1:MAX_LAT];
    logic [3:0]          slot_mask_q [1:MAX_LAT];
    logic [3:0]          slot_mask_d [1:MAX_LAT];

    logic [4*ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [4*DW-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [3:0]          fifo_mask_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                iss_null, iss_fire, collide, credit_ok;
    logic [3:0]          iss_mask;
    int unsigned         iss_lat, occ;
    logic                push, pop;
    logic [4*DW-1:0]     push_data;

    // Issue decode, collision and credit checks.
    always_comb begin
        iss_null = (iss_opcode == 2'b11) || ((iss_opcode == 2'b10) && !iss_radix);
        iss_mask = (iss_opcode == 2'b10) ? 4'b0011 : 4'b1111;
        if (iss_opcode == 2'b10) begin
            iss_lat = LAT_PWM;
        end else if (iss_radix) begin
            iss_lat = LAT_R4;
        end else begin
            iss_lat = LAT_R2;
        end
        // Target slot L is filled next cycle by whatever currently sits in L+1.
        collide = 1'b0;
        for (int unsigned k = 1; k < MAX_LAT; k++) begin
            if (k == iss_lat) collide = slot_vld_q[k+1];
        end
        occ = 0;
        for (int unsigned k = 1; k <= MAX_LAT; k++) begin
            occ = occ + {31'b0, slot_vld_q[k]};
        end
        credit_ok = (occ + 32'(cnt_q)) < FIFO_DEPTH;
        iss_ready = iss_null || (!collide && credit_ok);
        iss_fire  = iss_valid && iss_ready && !iss_null;
    end

    // Delay-line next state: shift toward slot 1, insert the new token at slot L.
    always_comb begin
        for (int unsigned k = 1; k <= MAX_LAT; k++) begin
            slot_vld_d[k]  = 1'b0;
            slot_addr_d[k] = '0;
            slot_mask_d[k] = '0;
        end
        for (int unsigned k = 1; k < MAX_LAT; k++) begin
            slot_vld_d[k]  = slot_vld_q[k+1];
            slot_addr_d[k] = slot_addr_q[k+1];
            slot_mask_d[k] = slot_mask_q[k+1];
        end
        if (iss_fire) begin
            for (int unsigned k = 1; k <= MAX_LAT; k++) begin
                if (k == iss_lat) begin
                    slot_vld_d[k]  = 1'b1;
                    slot_addr_d[k] = iss_addr;
                    slot_mask_d[k] = iss_mask;
                end
            end
        end
    end

    // Pair the token in slot 1 with this cycle's RBFU result; disabled lanes carry 0.
    always_comb begin
        push = slot_vld_q[1];
        for (int unsigned k = 0; k < 4; k++) begin
            push_data[k*DW +: DW] = slot_mask_q[1][k] ? rbfu_dout[k*DW +: DW] : '0;
        end
    end

    assign wb_valid = (cnt_q != '0);
    assign pop      = wb_valid && wb_ready;

    // Delay line and FIFO state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld_q <= '0;
            for (int unsigned k = 1; k <= MAX_LAT; k++) begin
                slot_addr_q[k] <= '0;
                slot_mask_q[k] <= '0;
            end
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
                fifo_mask_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            for (int unsigned k = 1; k <= MAX_LAT; k++) begin
                slot_addr_q[k] <= slot_addr_d[k];
                slot_mask_q[k] <= slot_mask_d[k];
            end
            // Credit accounting guarantees a free entry whenever push is set.
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= slot_addr_q[1];
                fifo_data_q[wr_ptr_q] <= push_data;
                fifo_mask_q[wr_ptr_q] <= slot_mask_q[1];
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FWFT head; outputs read as zero while the FIFO is empty.
    always_comb begin
        wb_addr = wb_valid ? fifo_addr_q[rd_ptr_q] : '0;
        wb_data = wb_valid ? fifo_data_q[rd_ptr_q] : '0;
        wb_mask = wb_valid ? fifo_mask_q[rd_ptr_q] : '0;
        busy    = (|slot_vld_q) || wb_valid;
    end

`ifdef RBFU_WB_RANGE_CHECK_EN
    logic range_hit;
    logic err_q;

    // Flag any enabled lane at push whose value is not a reduced coefficient.
    always_comb begin
        range_hit = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (push && slot_mask_q[1][k] && (rbfu_dout[k*DW +: DW] >= DW'(3329))) begin
                range_hit = 1'b1;
            end
        end
    end

    // Sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (range_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rbfu_writeback.sv
// Self-checking bench for rbfu_writeback: table-driven issue/handshake steps,
// a scoreboard queue of expected writes, and directed reset / range sequences.
module tb_rbfu_writeback;

    localparam int DW = 12;
    localparam int AW = 8;
    localparam int OP_NTT = 0;
    localparam int OP_INTT = 1;
    localparam int OP_PWM = 2;
    localparam int OP_NONE = 3;

    logic            clk;
    logic            rst;
    logic            iss_valid;
    logic            iss_ready;
    logic [1:0]      iss_opcode;
    logic            iss_radix;
    logic [4*AW-1:0] iss_addr;
    logic [4*DW-1:0] rbfu_dout;
    logic            wb_valid;
    logic            wb_ready;
    logic [4*AW-1:0] wb_addr;
    logic [4*DW-1:0] wb_data;
    logic [3:0]      wb_mask;
    logic            busy;
    logic            err;

    rbfu_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_opcode (iss_opcode),
        .iss_radix  (iss_radix),
        .iss_addr   (iss_addr),
        .rbfu_dout  (rbfu_dout),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_mask    (wb_mask),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            v;
        logic [1:0]      op;
        logic            rad;
        logic            wbr;
        int              er;   // expected iss_ready, 2 = don't care
        int              ev;   // expected wb_valid, 2 = don't care
        int              eb;   // expected busy, 2 = don't care
        logic [4*AW-1:0] addr;
    } step_t;

    typedef struct {
        logic [4*AW-1:0] addr;
        logic [4*DW-1:0] data;
        logic [3:0]      mask;
    } exp_t;

    exp_t            sbq[$];
    step_t           tbl[$];
    int              n_checks = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              ovr_cyc = -1;
    logic [4*DW-1:0] ovr_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic step_t mk(int v, int op, int rad, int wbr, int er, int ev, int eb);
        step_t s;
        s.v = (v != 0);
        s.op = 2'(op);
        s.rad = (rad != 0);
        s.wbr = (wbr != 0);
        s.er = er;
        s.ev = ev;
        s.eb = eb;
        s.addr = '0;
        return s;
    endfunction

    // RBFU output pattern per bench cycle, with one overridable cycle.
    function automatic logic [4*DW-1:0] pat(int c);
        logic [4*DW-1:0] r;
        if (c == ovr_cyc) return ovr_val;
        for (int k = 0; k < 4; k++) r[k*DW +: DW] = DW'((c * 37 + k * 11 + 5) % 3329);
        return r;
    endfunction

    function automatic logic is_null(logic [1:0] op, logic rad);
        return (op == 2'd3) || ((op == 2'd2) && !rad);
    endfunction

    function automatic int lat(logic [1:0] op, logic rad);
        if (op == 2'd2) return 2;
        return rad ? 2 : 1;
    endfunction

    task automatic step(input step_t s);
        exp_t e;
        logic [4*DW-1:0] d;
        iss_valid  = s.v;
        iss_opcode = s.op;
        iss_radix  = s.rad;
        iss_addr   = s.addr;
        wb_ready   = s.wbr;
        rbfu_dout  = pat(cyc);
        @(negedge clk);
        if (s.er != 2) chk("iss_ready", 64'(iss_ready), 64'(s.er));
        if (s.ev != 2) chk("wb_valid", 64'(wb_valid), 64'(s.ev));
        if (s.eb != 2) chk("busy", 64'(busy), 64'(s.eb));
        if (s.v && (s.er == 1) && !is_null(s.op, s.rad)) begin
            d = pat(cyc + lat(s.op, s.rad));
            e.mask = (s.op == 2'd2) ? 4'b0011 : 4'b1111;
            for (int k = 0; k < 4; k++) if (!e.mask[k]) d[k*DW +: DW] = '0;
            e.addr = s.addr;
            e.data = d;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Scoreboard: head must match while valid (covers hold under stall); pop on handshake.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_write", 64'(wb_valid), 64'(0));
            end else begin
                chk("wb_addr", 64'(wb_addr), 64'(sbq[0].addr));
                chk("wb_data", 64'(wb_data), 64'(sbq[0].data));
                chk("wb_mask", 64'(wb_mask), 64'(sbq[0].mask));
                if (wb_ready) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        step_t s;
        logic [7:0] a;
        rst = 1'b1;
        iss_valid = 1'b0;
        iss_opcode = 2'd0;
        iss_radix = 1'b0;
        iss_addr = '0;
        rbfu_dout = '0;
        wb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("rst_wb_valid", 64'(wb_valid), 64'(0));
        chk("rst_wb_addr", 64'(wb_addr), 64'(0));
        chk("rst_wb_data", 64'(wb_data), 64'(0));
        chk("rst_wb_mask", 64'(wb_mask), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_iss_ready", 64'(iss_ready), 64'(1));
        @(posedge clk);
        #1;

        // Single rad2 NTT
        tbl.push_back(mk(1, OP_NTT, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, OP_NONE, 0, 1, 2, 0, 1));
        tbl.push_back(mk(0, OP_NONE, 0, 1, 2, 1, 1));
        tbl.push_back(mk(0, OP_NONE, 0, 1, 2, 0, 0));
        // Collision: rad4 then rad2 held
        tbl.push_back(mk(1, OP_NTT, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, OP_NTT, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, OP_NTT, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, OP_NONE, 0, 1, 2, 1, 1));
        tbl.push_back(mk(0, OP_NONE, 0, 1, 2, 1, 1));
        tbl.push_back(mk(0, OP_NONE, 0, 1, 2, 0, 0));
        // INTT mixed latencies
        tbl.push_back(mk(1, OP_INTT, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, OP_INTT, 1, 1, 1, 0, 1));
        tbl.push_back(mk(1, OP_INTT, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, OP_INTT, 0, 1, 1, 1, 1));
        tbl.push_back(mk(0, OP_NONE, 0, 1, 2, 1, 1));
        tbl.push_back(mk(0, OP_NONE, 0, 1, 2, 1, 1));
        tbl.push_back(mk(0, OP_NONE, 0, 1, 2, 0, 0));
        // Back-pressure: four accepted, null still accepted when full
        tbl.push_back(mk(1, OP_NTT, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, OP_NTT, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, OP_NTT, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, OP_NTT, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, OP_NTT, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, OP_NTT, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, OP_NONE, 0, 0, 1, 1, 1));
        tbl.push_back(mk(0, OP_NTT, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, OP_NTT, 0, 1, 1, 1, 1));
        tbl.push_back(mk(0, OP_NTT, 0, 1, 1, 1, 1));
        tbl.push_back(mk(0, OP_NTT, 0, 1, 1, 1, 1));
        tbl.push_back(mk(0, OP_NTT, 0, 1, 1, 0, 0));
        // PWM and null tokens
        tbl.push_back(mk(1, OP_PWM, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, OP_NONE, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, OP_PWM, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, OP_NONE, 0, 1, 2, 1, 1));
        tbl.push_back(mk(0, OP_NONE, 0, 1, 2, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            a = 8'(i * 4);
            tbl[i].addr = {a + 8'd3, a + 8'd2, a + 8'd1, a};
        end

        ovr_cyc = cyc + 1;
        ovr_val = {12'd40, 12'd30, 12'd20, 12'd10};
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset mid-flight with three tokens in the pipe
        for (int i = 0; i < 3; i++) begin
            s = mk(1, OP_NTT, 0, 0, 1, 2, 2);
            s.addr = {8'(200 + i), 8'(210 + i), 8'(220 + i), 8'(230 + i)};
            step(s);
        end
        iss_valid = 1'b0;
        iss_opcode = 2'd0;
        rst = 1'b1;
        #2;
        chk("mid_rst_wb_valid", 64'(wb_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_wb_data", 64'(wb_data), 64'(0));
        chk("mid_rst_iss_ready", 64'(iss_ready), 64'(1));
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(mk(0, OP_NONE, 0, 1, 2, 0, 0));
        ovr_cyc = cyc + 1;
        ovr_val = {12'd40, 12'd30, 12'd20, 12'd10};
        s = mk(1, OP_NTT, 0, 1, 1, 0, 0);
        s.addr = {8'd3, 8'd2, 8'd1, 8'd0};
        step(s);
        step(mk(0, OP_NONE, 0, 1, 2, 0, 1));
        step(mk(0, OP_NONE, 0, 1, 2, 1, 1));
        step(mk(0, OP_NONE, 0, 1, 2, 0, 0));

`ifdef RBFU_WB_RANGE_CHECK_EN
        // Out-of-range value on a masked PWM lane must not set err
        ovr_cyc = cyc + 2;
        ovr_val = {12'd7, 12'd4000, 12'd22, 12'd11};
        s = mk(1, OP_PWM, 1, 1, 1, 0, 0);
        s.addr = {8'd90, 8'd91, 8'd92, 8'd93};
        step(s);
        step(mk(0, OP_NONE, 0, 1, 2, 0, 1));
        step(mk(0, OP_NONE, 0, 1, 2, 0, 1));
        step(mk(0, OP_NONE, 0, 1, 2, 1, 1));
        chk("err_masked_lane", 64'(err), 64'(0));
        // 3329 on an enabled lane sets err from the push edge onward
        ovr_cyc = cyc + 1;
        ovr_val = {12'd1, 12'd2, 12'd3, 12'd3329};
        s = mk(1, OP_NTT, 0, 1, 1, 0, 0);
        s.addr = {8'd80, 8'd81, 8'd82, 8'd83};
        step(s);
        chk("err_before_push", 64'(err), 64'(0));
        step(mk(0, OP_NONE, 0, 1, 2, 0, 1));
        chk("err_after_push", 64'(err), 64'(1));
        step(mk(0, OP_NONE, 0, 1, 2, 1, 1));
        step(mk(0, OP_NONE, 0, 1, 2, 0, 0));
        chk("err_sticky", 64'(err), 64'(1));
`else
        chk("err_tied_low", 64'(err), 64'(0));
`endif

        chk("sb_drained", 64'(sbq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rbfu_writeback.md
Name: rbfu_writeback

Overview:
- Write-back side of the RBFU datapath: takes issue tokens (destination addresses, opcode, radix) as operand sets are launched into the RBFU, and aligns each token with the RBFU result after the opcode/radix-dependent latency.
- Captures the four result lanes into an output FIFO and presents them to the coefficient-memory write port with a valid/ready handshake.
- Issue-side back-pressure prevents output-slot collisions and FIFO overflow.

Parameters:
- DW, 12, coefficient width (matches RBFU).
- ADDR_W, 8, per-lane memory address width.
- LAT_R2, 1, RBFU latency for radix-2 NTT/INTT (cycles).
- LAT_R4, 2, RBFU latency for radix-4 NTT/INTT.
- LAT_PWM, 2, RBFU latency for PWM.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- iss_valid  in  1  operand set launched into RBFU this cycle.
- iss_ready  out  1  writeback can accept the token.
- iss_opcode  in  2  00 NTT, 01 INTT, 10 PWM, 11 none.
- iss_radix  in  1  0 RAD2, 1 RAD4.
- iss_addr  in  4*ADDR_W  destination addresses, lane k at [k*ADDR_W +: ADDR_W].
- rbfu_dout  in  4*DW  RBFU Dout0..Dout3, lane k at [k*DW +: DW].
- wb_valid  out  1  write request valid.
- wb_ready  in  1  memory accepts the write.
- wb_addr  out  4*ADDR_W  lane addresses.
- wb_data  out  4*DW  lane data.
- wb_mask  out  4  per-lane write enable.
- busy  out  1  any token in flight or in the FIFO.
- err  out  1  sticky range error (optional feature only; otherwise tied 0).

Behaviour:
- Reset:
  - Delay line and FIFO cleared.
  - Outputs: wb_valid=0, wb_addr=0, wb_data=0, wb_mask=0, busy=0, err=0.
  - iss_ready reflects the empty state and is 1 when rst is deasserted.
- Latency selection:
  - L = LAT_R2 if radix=0 and opcode is NTT/INTT.
  - L = LAT_R4 if radix=1 and opcode is NTT/INTT.
  - L = LAT_PWM for PWM with radix=1.
  - PWM with radix=0 and opcode 11 are "null": accepted (iss_ready=1 irrespective of state), produce no FIFO entry.
- Timing: a token accepted in cycle t (iss_valid & iss_ready) pairs with rbfu_dout in cycle t+L. That data, with the token's addresses and mask, is pushed into the FIFO at the edge closing cycle t+L. Earliest wb_valid is cycle t+L+1.
- Delay line: slot array indexed by remaining cycles (1..max L) holding valid, addr, mask. Shifts every cycle.
- Collision rule: iss_ready=0 for a non-null token if its arrival slot L is already occupied.
- Credit rule: iss_ready=0 if (occupied slots + FIFO count) >= FIFO_DEPTH. This guarantees a FIFO push never overflows; no data is ever dropped.
- Masks: NTT/INTT produce 1111; PWM produces 0011 (lanes 2,3 written as 0 data).
- FIFO:
  - First-word-fall-through; wb_* driven from the head.
  - Pop on wb_valid & wb_ready.
  - Push and pop in the same cycle are allowed, including at full.
  - wb_* hold stable while wb_valid=1 and wb_ready=0.
  - Write order equals issue order of non-null tokens. Collision avoidance makes arrival order well defined even when latencies differ.
- busy = any slot valid or FIFO non-empty.
- Reset mid-operation: all in-flight tokens and buffered entries are discarded; no write issued after rst.

Optional Feature:
- Macro: RBFU_WB_RANGE_CHECK_EN.
- When defined:
  - At push, any enabled lane with data >= 3329 sets err.
  - err stays set until rst.
  - The data is still written unchanged.
- When undefined: no comparators; err is constant 0.

Test Plan:
- Single rad2 NTT: reset, issue opcode 00, radix 0, addr {3,2,1,0} at cycle 0; rbfu_dout lanes {40,30,20,10} at cycle 1; wb_ready=1 -> wb_valid in cycle 2 only, addr {3,2,1,0}, data {40,30,20,10}, mask 1111; busy falls after cycle 2.
- Collision: rad4 NTT (L=2) at cycle 0, then rad2 token held valid from cycle 1 -> iss_ready=0 in cycle 1, accepted cycle 2. Writes in order rad4 (cycle 3), rad2 (cycle 4).
- Back-pressure: wb_ready=0, continuous rad2 issues -> exactly 4 accepted, then iss_ready=0. Raise wb_ready -> 4 writes in issue order, then iss_ready=1.
- PWM and null: PWM radix 1 -> mask 0011 after LAT_PWM+1 cycles. Opcode 11 and PWM radix 0 -> accepted, no write.
- Reset mid-flight: 3 tokens in flight/FIFO, assert rst for 1 cycle -> wb_valid=0, busy=0, no later writes; next issue behaves as in the single rad2 NTT scenario.
- With RBFU_WB_RANGE_CHECK_EN: lane data 3329 on an NTT token -> err=1 from push onward, data written as 3329. PWM lane 2 junk 4000 (masked) -> err stays 0.
